// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, schedule FSM state type and the small/big sigma helpers.
package sha256_pkg;

   localparam int unsigned WORD_W     = 32;
   localparam int unsigned ROUNDS     = 64;
   localparam int unsigned LOAD_WORDS = 16;
   localparam int unsigned IDX_W      = $clog2(ROUNDS);
   localparam int unsigned CNT_W      = $clog2(LOAD_WORDS);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      EMIT
   } sched_state_e;

   function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   // Round-stage compression helpers, kept alongside the schedule ones.
   function automatic logic [WORD_W-1:0] big_sigma0(input logic [WORD_W-1:0] x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction

   function automatic logic [WORD_W-1:0] big_sigma1(input logic [WORD_W-1:0] x);
      return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
   endfunction

endpackage

// File: rtl/sha256_sched_sigma.sv
// Combinational schedule expansion: W[t+16] from the W[t], W[t+1], W[t+9], W[t+14] taps.
module sha256_sched_sigma
   import sha256_pkg::*;
(
   input  logic [WORD_W-1:0] i_w0,
   input  logic [WORD_W-1:0] i_w1,
   input  logic [WORD_W-1:0] i_w9,
   input  logic [WORD_W-1:0] i_w14,
   output logic [WORD_W-1:0] o_new
);

   assign o_new = sigma1(i_w14) + i_w9 + sigma0(i_w1) + i_w0;

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads 16 words, streams W[0..63] over valid/ready.
// Optional synchronous cancel input enabled by `define SCHED_ABORT_EN.
module sha256_msg_schedule
   import sha256_pkg::*;
(
   input  logic              clock,
   input  logic              ctrl_reset,
`ifdef SCHED_ABORT_EN
   input  logic              abort,
`endif
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_data,
   output logic [IDX_W-1:0]  out_index,
   output logic              busy,
   output logic              done
);

   sched_state_e      r_state;
   sched_state_e      w_state_nxt;
   logic [WORD_W-1:0] r_window [LOAD_WORDS];
   logic [CNT_W-1:0]  r_load_cnt;
   logic [IDX_W-1:0]  r_t;
   logic              r_done;
   logic              w_abort;
   logic              w_in_xfer;
   logic              w_out_xfer;
   logic              w_load_last;
   logic              w_emit_last;
   logic [WORD_W-1:0] w_new_word;

`ifdef SCHED_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   // Abort wins over any handshake in the same cycle.
   assign w_in_xfer   = in_valid & in_ready & ~w_abort;
   assign w_out_xfer  = out_valid & out_ready & ~w_abort;
   assign w_load_last = (r_state == LOAD) && (r_load_cnt == CNT_W'(LOAD_WORDS - 1));
   assign w_emit_last = (r_t == IDX_W'(ROUNDS - 1));

   sha256_sched_sigma u_sigma (
      .i_w0  (r_window[0]),
      .i_w1  (r_window[1]),
      .i_w9  (r_window[9]),
      .i_w14 (r_window[14]),
      .o_new (w_new_word)
   );

   always_ff @(posedge clock or negedge ctrl_reset) begin
      if (!ctrl_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_abort) begin
         w_state_nxt = IDLE;
      end else begin
         unique case (r_state)
            IDLE:    if (w_in_xfer) w_state_nxt = LOAD;
            LOAD:    if (w_in_xfer && w_load_last) w_state_nxt = EMIT;
            EMIT:    if (w_out_xfer && w_emit_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (r_state)
         IDLE: begin
            in_ready = 1'b1;
         end
         LOAD: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
         EMIT: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: begin
            in_ready = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock or negedge ctrl_reset) begin
      if (!ctrl_reset) begin
         for (int k = 0; k < int'(LOAD_WORDS); k++) begin
            r_window[k] <= '0;
         end
         r_load_cnt <= '0;
         r_t        <= '0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_abort) begin
            r_load_cnt <= '0;
            r_t        <= '0;
         end else if (w_in_xfer) begin
            for (int k = 0; k < int'(LOAD_WORDS) - 1; k++) begin
               r_window[k] <= r_window[k+1];
            end
            r_window[LOAD_WORDS-1] <= in_data;
            if (w_load_last) begin
               r_load_cnt <= '0;
               r_t        <= '0;
            end else begin
               r_load_cnt <= r_load_cnt + 1'b1;
            end
         end else if (w_out_xfer) begin
            for (int k = 0; k < int'(LOAD_WORDS) - 1; k++) begin
               r_window[k] <= r_window[k+1];
            end
            r_window[LOAD_WORDS-1] <= w_new_word;
            if (w_emit_last) begin
               r_t    <= '0;
               r_done <= 1'b1;
            end else begin
               r_t <= r_t + 1'b1;
            end
         end
      end
   end

   assign out_data  = r_window[0];
   assign out_index = r_t;
   assign done      = r_done;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule; exercises the abort port when SCHED_ABORT_EN is set.
module tb_sha256_msg_schedule;

   typedef logic [31:0] blk_t [16];
   typedef logic [31:0] sch_t [64];
   typedef struct {
      int          blk;
      int          t;
      logic [31:0] exp;
   } vec_t;

   logic        clock = 1'b0;
   logic        ctrl_reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [5:0]  out_index;
   logic        busy;
   logic        done;
`ifdef SCHED_ABORT_EN
   logic        abort;
`endif

   int n_checks = 0;
   int n_errors = 0;

   sha256_msg_schedule dut (
      .clock      (clock),
      .ctrl_reset (ctrl_reset),
`ifdef SCHED_ABORT_EN
      .abort      (abort),
`endif
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_index  (out_index),
      .busy       (busy),
      .done       (done)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, {31'b0, act}, {31'b0, exp});
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic void golden(input blk_t b, output sch_t w);
      for (int i = 0; i < 16; i++) w[i] = b[i];
      for (int i = 16; i < 64; i++) begin
         w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
              + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
      end
   endfunction

   // Called #1 after a clock edge; returns #1 after the edge of the last transfer.
   task automatic load_block(input blk_t b, input int n, input bit gaps);
      int  i   = 0;
      int  cyc = 0;
      logic xfer;
      while (i < n && cyc < 500) begin
         if (gaps && ($urandom_range(0, 2) == 0)) begin
            in_valid = 1'b0;
            in_data  = 32'hbad0_bad0;
         end else begin
            in_valid = 1'b1;
            in_data  = b[i];
         end
         xfer = in_valid & in_ready;
         @(posedge clock);
         #1;
         cyc++;
         if (xfer) i++;
      end
      in_valid = 1'b0;
      if (i < n) chk("load_timeout", 32'(i), 32'(n));
      if (n == 16) begin
         chk1("out_valid_after_load", out_valid, 1'b1);
         chk1("in_ready_after_load", in_ready, 1'b0);
      end
   endtask

   task automatic emit_n(input int n);
      int got = 0;
      int cyc = 0;
      while (got < n && cyc < 500) begin
         out_ready = 1'b1;
         if (out_valid) got++;
         @(posedge clock);
         #1;
         cyc++;
      end
      out_ready = 1'b0;
      if (got < n) chk("emit_timeout", 32'(got), 32'(n));
   endtask

   task automatic collect(input bit stall, input bit poke_in, output sch_t w,
                          output int first, output int first_to_done);
      int          got = 0;
      int          cyc = 0;
      bit          was_stalled = 1'b0;
      logic [31:0] held = '0;
      logic [5:0]  held_idx = '0;
      first = -1;
      while (got < 64 && cyc < 2000) begin
         out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (poke_in) begin
            in_valid = 1'b1;
            in_data  = 32'hdead_beef;
         end
         chk1("done_early", done, 1'b0);
         if (out_valid) begin
            if (first < 0) first = cyc;
            if (poke_in) chk1("in_ready_in_emit", in_ready, 1'b0);
            if (was_stalled) begin
               chk("stall_data_hold", out_data, held);
               chk("stall_index_hold", {26'b0, out_index}, {26'b0, held_idx});
            end
            if (out_ready) begin
               chk("out_index", {26'b0, out_index}, 32'(got));
               w[got] = out_data;
               got++;
            end
            was_stalled = ~out_ready;
            held        = out_data;
            held_idx    = out_index;
         end
         @(posedge clock);
         #1;
         cyc++;
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      if (got < 64) chk("collect_timeout", 32'(got), 32'd64);
      first_to_done = cyc - first;
      chk1("done_pulse", done, 1'b1);
      chk1("done_in_ready", in_ready, 1'b1);
      chk1("done_out_valid", out_valid, 1'b0);
      chk("done_out_index", {26'b0, out_index}, 32'd0);
   endtask

   blk_t blk [3];
   sch_t gold [3];
   sch_t cap [3];
   sch_t w_tmp;
   sch_t w_stalled;
   vec_t vecs [16];
   int   first;
   int   f2d;

   initial begin
      for (int b = 0; b < 3; b++) for (int i = 0; i < 16; i++) blk[b][i] = '0;
      blk[0][0]  = 32'h6162_6380;  // "abc" padded
      blk[0][15] = 32'h0000_0018;
      blk[1][0]  = 32'h0000_0001;
      vecs[0]  = '{0, 0,  32'h6162_6380};
      vecs[1]  = '{0, 1,  32'h0000_0000};
      vecs[2]  = '{0, 15, 32'h0000_0018};
      vecs[3]  = '{0, 16, 32'h6162_6380};
      vecs[4]  = '{0, 17, 32'h000F_0000};
      vecs[5]  = '{1, 0,  32'h0000_0001};
      vecs[6]  = '{1, 16, 32'h0000_0001};
      vecs[7]  = '{1, 17, 32'h0000_0000};
      vecs[8]  = '{1, 18, 32'h0000_A000};
      vecs[9]  = '{1, 19, 32'h0000_0000};
      vecs[10] = '{1, 20, 32'h4400_0028};
      vecs[11] = '{1, 21, 32'h0000_0000};
      vecs[12] = '{1, 23, 32'h0000_0001};
      vecs[13] = '{2, 0,  32'h0000_0000};
      vecs[14] = '{2, 40, 32'h0000_0000};
      vecs[15] = '{2, 63, 32'h0000_0000};
      for (int b = 0; b < 3; b++) begin
         golden(blk[b], w_tmp);
         gold[b] = w_tmp;
      end

      ctrl_reset = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      out_ready  = 1'b0;
`ifdef SCHED_ABORT_EN
      abort      = 1'b0;
`endif
      repeat (3) @(posedge clock);
      #1;
      chk1("rst_in_ready", in_ready, 1'b1);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_out_index", {26'b0, out_index}, 32'd0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      #3 ctrl_reset = 1'b1;
      @(posedge clock);
      #1;

      // Unstalled "abc", then a back-to-back block with in_valid held high during EMIT.
      load_block(blk[0], 16, 1'b0);
      collect(1'b0, 1'b0, w_tmp, first, f2d);
      cap[0] = w_tmp;
      chk("abc_first_latency", 32'(first), 32'd0);
      chk("abc_done_delay", 32'(f2d), 32'd64);
      load_block(blk[1], 16, 1'b0);
      collect(1'b0, 1'b1, w_tmp, first, f2d);
      cap[1] = w_tmp;
      chk("b2b_done_delay", 32'(f2d), 32'd64);

      // Input gaps plus random backpressure.
      load_block(blk[2], 16, 1'b1);
      collect(1'b1, 1'b0, w_tmp, first, f2d);
      cap[2] = w_tmp;
      load_block(blk[0], 16, 1'b1);
      collect(1'b1, 1'b0, w_stalled, first, f2d);

      for (int v = 0; v < 16; v++) begin
         chk($sformatf("vec%0d_blk%0d_W%0d", v, vecs[v].blk, vecs[v].t),
             cap[vecs[v].blk][vecs[v].t], vecs[v].exp);
      end
      for (int b = 0; b < 3; b++) begin
         for (int t = 0; t < 64; t++) chk($sformatf("gold_blk%0d_W%0d", b, t), cap[b][t], gold[b][t]);
      end
      for (int t = 0; t < 64; t++) chk($sformatf("stalled_W%0d", t), w_stalled[t], gold[0][t]);

      // Asynchronous reset in the middle of EMIT, checked before the next edge.
      load_block(blk[0], 16, 1'b0);
      emit_n(20);
      #2 ctrl_reset = 1'b0;
      #1;
      chk1("async_rst_out_valid", out_valid, 1'b0);
      chk1("async_rst_in_ready", in_ready, 1'b1);
      chk("async_rst_out_index", {26'b0, out_index}, 32'd0);
      chk1("async_rst_busy", busy, 1'b0);
      chk("async_rst_out_data", out_data, 32'h0);
      @(posedge clock);
      #3 ctrl_reset = 1'b1;
      @(posedge clock);
      #1;
      load_block(blk[1], 16, 1'b0);
      collect(1'b0, 1'b0, w_tmp, first, f2d);
      for (int t = 0; t < 64; t++) chk($sformatf("post_rst_W%0d", t), w_tmp[t], gold[1][t]);

`ifdef SCHED_ABORT_EN
      // Abort after seven loaded words, with a word offered in the same cycle.
      load_block(blk[1], 7, 1'b0);
      abort    = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'hffff_ffff;
      @(posedge clock);
      #1;
      abort    = 1'b0;
      in_valid = 1'b0;
      chk1("abort_load_busy", busy, 1'b0);
      chk1("abort_load_in_ready", in_ready, 1'b1);
      load_block(blk[0], 16, 1'b0);
      collect(1'b0, 1'b0, w_tmp, first, f2d);
      chk("abort_load_W16", w_tmp[16], 32'h6162_6380);
      for (int t = 0; t < 64; t++) chk($sformatf("abort_load_W%0d", t), w_tmp[t], gold[0][t]);

      // Abort at t=30 while the downstream is ready.
      load_block(blk[0], 16, 1'b0);
      emit_n(30);
      chk("abort_emit_t", {26'b0, out_index}, 32'd30);
      abort     = 1'b1;
      out_ready = 1'b1;
      @(posedge clock);
      #1;
      abort     = 1'b0;
      out_ready = 1'b0;
      chk1("abort_emit_out_valid", out_valid, 1'b0);
      chk1("abort_emit_done", done, 1'b0);
      chk1("abort_emit_busy", busy, 1'b0);
      chk("abort_emit_index", {26'b0, out_index}, 32'd0);
      @(posedge clock);
      #1;
      chk1("abort_emit_done_late", done, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
